// File: rtl/key_debounce_multi_pkg.sv
// Shared constants and sizing helper for the multi-key debouncer.
package key_pkg;

  localparam int KEY_DEBOUNCE_20MS_50M = 1000000;
  localparam int KEY_LONG_1S_50M       = 50000000;

  // Width of a counter that has to hold values 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_multi_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, level and event pulses.
// Long-press hold counter is built only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_20MS_50M,
  parameter int LONG_PRESS_CYCLES = KEY_LONG_1S_50M,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          REL_LVL = (ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          sync_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // XOR with the released level turns the raw pin into "1 = pressed".
  assign sync_s = sync_q[1] ^ REL_LVL;

  // Synchroniser comes out of reset at the released pin level so no false edge is seen.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q    <= {2{REL_LVL}};
      cnt_q     <= {CW{1'b0}};
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key};
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_s == state_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d     = {CW{1'b0}};
      state_d   = sync_s;
      press_d   = sync_s;
      release_d = ~sync_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int            HW       = cnt_width(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold counter saturates, so the long pulse can only fire once per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q <= {HW{1'b0}};
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Count held cycles; the pulse coincides with the counter reaching HOLD_MAX.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!state_q) begin
      hold_d = {HW{1'b0}};
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == HOLD_MAX - HW'(1));
    end else begin
      hold_d = hold_q;
    end
  end

  assign key_long = long_q;
`else
  // Feature compiled out; the term keeps the hold-time parameter referenced.
  assign key_long = 1'b0 && (LONG_PRESS_CYCLES > 0);
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// NUM_KEYS independent debounce channels behind one port set.
// Optional long-press detection: define KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = KEY_DEBOUNCE_20MS_50M,
  parameter int LONG_PRESS_CYCLES = KEY_LONG_1S_50M,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key[g]),
      .key_state  (key_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench: directed scenarios plus random pin activity against a window-based model.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int DB = 16;
  localparam int LP = 64;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  key_debounce_multi #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pins pass through a two-sample delay; a channel flips once the
  // last DB samples since its previous flip all disagree with the accepted level.
  bit            pipe0 [NK];
  bit            pipe1 [NK];
  bit            mstate[NK];
  bit [DB-1:0]   hist  [NK];
  int            nsince[NK];
  int            pedge [NK];
  int            cyc;
  logic [NK-1:0] e_state, e_press, e_rel, e_long;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NK; c++) begin
      pipe0[c] = 1'b0; pipe1[c] = 1'b0; mstate[c] = 1'b0;
      hist[c] = '0; nsince[c] = 0; pedge[c] = -1;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_edge();
    bit v, flip;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    cyc++;
    for (int c = 0; c < NK; c++) begin
      v        = pipe1[c];
      pipe1[c] = pipe0[c];
      pipe0[c] = ~key[c];
      hist[c]  = {hist[c][DB-2:0], v};
      nsince[c]++;
      flip = (nsince[c] >= DB) && (hist[c] == (mstate[c] ? {DB{1'b0}} : {DB{1'b1}}));
      e_press[c] = flip && v;
      e_rel[c]   = flip && !v;
      if (flip) begin
        mstate[c] = v;
        nsince[c] = 0;
        pedge[c]  = v ? cyc : -1;
      end
      e_state[c] = mstate[c];
      e_long[c]  = (pedge[c] >= 0) && (cyc - pedge[c] == LP);
    end
  endtask

  task automatic step();
    logic [NK-1:0] exp_long;
    @(posedge sys_clk);
    model_edge();
    #1;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    exp_long = e_long;
`else
    exp_long = '0;
`endif
    chk("state",   32'(key_state),   32'(e_state));
    chk("press",   32'(key_press),   32'(e_press));
    chk("release", 32'(key_release), 32'(e_rel));
    chk("long",    32'(key_long),    32'(exp_long));
    chk("excl",    32'(key_press & key_release), 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Steps until the chosen pulse shows on channel ch; lat = steps taken, -1 on timeout.
  task automatic wait_for(input int kind, input int ch, input int limit, output int lat);
    logic [NK-1:0] v;
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      v = (kind == 0) ? key_press : key_release;
      if (v[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, n_long, t_press, t_long, exp_nlong;
  int dur[NK];

  initial begin
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    exp_nlong = 1;
`else
    exp_nlong = 0;
`endif
    cyc = 0;
    key = 4'hF;
    sys_rst_n = 1'b0;
    model_reset();
    run(3);
    sys_rst_n = 1'b1;
    run(100);
    chk("rst_state", 32'(key_state), 32'd0);

    key[0] = 1'b0;
    wait_for(0, 0, 40, lat);
    chk("lat_press0", lat, 18);
    run(5);

    key[1] = 1'b0; run(5);
    key[1] = 1'b1; run(3);
    key[1] = 1'b0; run(10);
    key[1] = 1'b1; run(2);
    key[1] = 1'b0;
    wait_for(0, 1, 40, lat);
    chk("lat_press1", lat, 18);

    key[3:2] = 2'b00;
    wait_for(0, 2, 40, lat);
    chk("lat_press2", lat, 18);
    chk("sim_press", 32'(key_press[3:2]), 32'd3);
    run(40 - 18);
    key[3:2] = 2'b11;
    wait_for(1, 3, 40, lat);
    chk("lat_rel3", lat, 18);
    chk("sim_rel", 32'(key_release[3:2]), 32'd3);

    key[0] = 1'b1;
    wait_for(1, 0, 40, lat);
    chk("lat_rel0", lat, 18);
    run(5);
    key[0] = 1'b0;
    n_long = 0; t_press = -1; t_long = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (key_press[0]) t_press = i;
      if (key_long[0]) begin n_long++; t_long = i; end
    end
    key[0] = 1'b1;
    run(30);
    chk("long_cnt", n_long, exp_nlong);
    if (exp_nlong == 1) chk("long_dly", t_long - t_press, LP);
    key[0] = 1'b0;
    n_long = 0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 41) key[0] = 1'b1;
      step();
      if (key_long[0]) n_long++;
    end
    chk("short_nolong", n_long, 0);

    key[0] = 1'b0;
    run(12);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_state", 32'(key_state), 32'd0);
    chk("midrst_pulse", 32'({key_press, key_release, key_long}), 32'd0);
    run(3);
    sys_rst_n = 1'b1;
    wait_for(0, 0, 40, lat);
    chk("lat_after_rst", lat, 18);
    chk("held1_after_rst", 32'(key_press[1]), 32'd1);

    for (int c = 0; c < NK; c++) dur[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NK; c++) begin
        if (dur[c] == 0) begin
          key[c] = 1'($urandom_range(0, 1));
          dur[c] = $urandom_range(1, 40);
        end
        dur[c]--;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
